data_cache_ctrl: RTL and testbench

//  Sequencing controller for the direct-mapped, write-through data_cache array. Accepts one
//  LSU load/store request at a time, compares tag and valid, and drives the array's enable,
//  op and index controls. Runs the DRAM read/fill on a load miss and the DRAM write-through
//  on every store, then returns a one-cycle response. Sits between the LSU, data_cache and
//  the DRAM port.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/data_cache_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared sizes and types for the direct-mapped write-through data_cache and its controller.
package cache_pkg;

  localparam int unsigned INDEX_COUNT = 256;
  localparam int unsigned IDX_W       = $clog2(INDEX_COUNT);
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TAG_W       = 22;
  localparam int unsigned ADDR_W      = TAG_W + IDX_W;
  localparam int unsigned DEF_STAT_W  = 16;

  typedef enum logic {
    LW = 1'b0,
    SW = 1'b1
  } lsu_ops;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    FILL   = 3'd3,
    MEM_WR = 3'd4,
    RESP   = 3'd5
  } ctrl_state_e;

  // One array line as written through write_index.
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cache_line_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/data_cache_ctrl.sv
// Sequencing controller for the write-through data_cache: lookup, load-miss fill,
// store write-through to DRAM, one-cycle response and saturating hit/miss counters.
module data_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned STAT_W = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  lsu_ops            req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              cache_enable,
  output lsu_ops            rd_wr_sel,
  output logic [IDX_W-1:0]  index_sel,
  output cache_line_t       write_index,
  input  logic [TAG_W-1:0]  cache_tag,
  input  logic              cache_valid,
  input  logic [DATA_W-1:0] cache_data_io,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
);

  ctrl_state_e       state_q, state_d;
  lsu_ops            op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              cache_enable_q, cache_enable_d;
  lsu_ops            rd_wr_sel_q, rd_wr_sel_d;
  cache_line_t       write_index_q, write_index_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [STAT_W-1:0] hit_count_q, hit_count_d;
  logic [STAT_W-1:0] miss_count_q, miss_count_d;
  logic              lookup_hit;

  // Array outputs are combinational on index_sel, which is the latched request index.
  assign lookup_hit = cache_valid && (cache_tag == addr_tag(addr_q));

  // Next-state and registered-output decode; outputs are set for the state being entered.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    hit_d          = hit_q;
    resp_valid_d   = 1'b0;
    req_ready_d    = 1'b0;
    cache_enable_d = 1'b0;
    write_index_d  = write_index_q;
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = !req_valid;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
          // Store is write-allocate: the array write happens during LOOKUP.
          if (req_op == SW) begin
            cache_enable_d = 1'b1;
            write_index_d  = '{valid: 1'b1, tag: addr_tag(req_addr), data: req_wdata};
          end
        end
      end

      LOOKUP: begin
        hit_d = lookup_hit;
        if (lookup_hit) begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + STAT_W'(1);
        end else begin
          if (miss_count_q != '1) miss_count_d = miss_count_q + STAT_W'(1);
        end
        if (op_q == SW) begin
          rdata_d   = '0;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
          state_d   = MEM_WR;
        end else if (lookup_hit) begin
          rdata_d      = cache_data_io;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          mem_req_d = 1'b1;
          state_d   = MEM_RD;
        end
      end

      MEM_RD: begin
        if (mem_ack) begin
          rdata_d        = mem_rdata;
          cache_enable_d = 1'b1;
          write_index_d  = '{valid: 1'b1, tag: addr_tag(addr_q), data: mem_rdata};
          state_d        = FILL;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      FILL: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end

      MEM_WR: begin
        if (mem_ack) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end
      end

      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase

    rd_wr_sel_d = cache_enable_d ? SW : LW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= LW;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      hit_q          <= 1'b0;
      resp_valid_q   <= 1'b0;
      req_ready_q    <= 1'b1;
      cache_enable_q <= 1'b0;
      rd_wr_sel_q    <= LW;
      write_index_q  <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      hit_q          <= hit_d;
      resp_valid_q   <= resp_valid_d;
      req_ready_q    <= req_ready_d;
      cache_enable_q <= cache_enable_d;
      rd_wr_sel_q    <= rd_wr_sel_d;
      write_index_q  <= write_index_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = rdata_q;
  assign resp_hit     = hit_q;
  assign cache_enable = cache_enable_q;
  assign rd_wr_sel    = rd_wr_sel_q;
  assign index_sel    = addr_idx(addr_q);
  assign write_index  = write_index_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: array and DRAM models plus a reference cache
// that predicts each response into a scoreboard queue.
module tb_data_cache_ctrl;
  import cache_pkg::*;

  localparam int unsigned TB_STAT_W = 4;
  localparam int          STAT_MAX  = (1 << TB_STAT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              hit;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  lsu_ops            req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              cache_enable;
  lsu_ops            rd_wr_sel;
  logic [IDX_W-1:0]  index_sel;
  cache_line_t       write_index;
  logic [TAG_W-1:0]  cache_tag;
  logic              cache_valid;
  logic [DATA_W-1:0] cache_data_io;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [TB_STAT_W-1:0] hit_count;
  logic [TB_STAT_W-1:0] miss_count;

  always #5 clk = ~clk;

  data_cache_ctrl #(.STAT_W(TB_STAT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .cache_enable(cache_enable), .rd_wr_sel(rd_wr_sel), .index_sel(index_sel),
    .write_index(write_index), .cache_tag(cache_tag), .cache_valid(cache_valid),
    .cache_data_io(cache_data_io),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Behavioural data_cache array.
  cache_line_t arr [INDEX_COUNT];
  logic        tb_clear;
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < INDEX_COUNT; i++) arr[i] <= '0;
    end else if (cache_enable && rd_wr_sel == SW) begin
      arr[index_sel] <= write_index;
    end
  end
  assign cache_valid   = arr[index_sel].valid;
  assign cache_tag     = arr[index_sel].tag;
  assign cache_data_io = arr[index_sel].data;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    if (a == {22'h3, 8'h05}) return 32'hDEADBEEF;
    return 32'h5A000000 ^ DATA_W'(a);
  endfunction

  // DRAM responder: acks after ack_delay cycles of mem_req.
  logic [DATA_W-1:0] dram [logic [ADDR_W-1:0]];
  int ack_delay = 3;
  bit ack_hold  = 1'b0;
  bit force_ack = 1'b0;
  int ack_cnt   = 0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (mem_req && !ack_hold) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        if (mem_we) dram[mem_addr] = mem_wdata;
        else        mem_rdata = dram.exists(mem_addr) ? dram[mem_addr] : pat(mem_addr);
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Reference cache state and expected counters.
  bit                ref_valid [INDEX_COUNT];
  logic [TAG_W-1:0]  ref_tag   [INDEX_COUNT];
  logic [DATA_W-1:0] ref_data  [INDEX_COUNT];
  logic [DATA_W-1:0] ref_mem   [logic [ADDR_W-1:0]];
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic predict(input lsu_ops op, input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] wd, output exp_t e, output int lat,
                         output int mreq, output int cen);
    logic [ADDR_W-1:0] a;
    a     = {tag, idx};
    e.hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (e.hit) begin
      if (exp_hits < STAT_MAX) exp_hits++;
    end else begin
      if (exp_misses < STAT_MAX) exp_misses++;
    end
    if (op == SW) begin
      e.rdata = '0; lat = 2 + ack_delay; mreq = ack_delay; cen = 1;
      ref_valid[idx] = 1'b1; ref_tag[idx] = tag; ref_data[idx] = wd; ref_mem[a] = wd;
    end else if (e.hit) begin
      e.rdata = ref_data[idx]; lat = 2; mreq = 0; cen = 0;
    end else begin
      e.rdata = ref_mem.exists(a) ? ref_mem[a] : pat(a);
      lat = 3 + ack_delay; mreq = ack_delay; cen = 1;
      ref_valid[idx] = 1'b1; ref_tag[idx] = tag; ref_data[idx] = e.rdata;
    end
  endtask

  // One complete request: predict, drive, watch the transaction and score the response.
  task automatic do_req(input lsu_ops op, input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                        input logic [DATA_W-1:0] wd);
    exp_t e, got;
    int lat, mreq, cen, n, wait_n, seen_mreq, seen_cen, mem_bad;
    bit seen;
    predict(op, tag, idx, wd, e, lat, mreq, cen);
    exp_q.push_back(e);
    wait_n = 0;
    @(negedge clk);
    while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    checks++;
    if (!req_ready) begin failures++; $display("FAIL req_ready_wait got=%b want=1", req_ready); end
    req_valid = 1'b1; req_op = op; req_addr = {tag, idx}; req_wdata = wd;
    @(posedge clk);
    n = 0; seen = 1'b0; seen_mreq = 0; seen_cen = 0; mem_bad = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) req_valid = 1'b0;
      if (mem_req) begin
        seen_mreq++;
        if (mem_we !== (op == SW) || mem_addr !== {tag, idx} || (op == SW && mem_wdata !== wd)) mem_bad++;
      end
      if (cache_enable && rd_wr_sel == SW) seen_cen++;
      if (resp_valid) seen = 1'b1;
    end
    got = exp_q.pop_front();
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL resp_timeout op=%s addr=%h got=none want=resp within 60", op.name(), {tag, idx});
      return;
    end
    checks++;
    if (n != lat) begin failures++; $display("FAIL latency addr=%h got=%0d want=%0d", {tag, idx}, n, lat); end
    checks++;
    if (seen_mreq != mreq) begin failures++; $display("FAIL mem_req_cycles got=%0d want=%0d", seen_mreq, mreq); end
    checks++;
    if (mem_bad != 0) begin failures++; $display("FAIL mem_fields bad_cycles got=%0d want=0", mem_bad); end
    checks++;
    if (seen_cen != cen) begin failures++; $display("FAIL array_writes got=%0d want=%0d", seen_cen, cen); end
    checks++;
    if (resp_rdata !== got.rdata) begin failures++; $display("FAIL resp_rdata got=%h want=%h", resp_rdata, got.rdata); end
    checks++;
    if (resp_hit !== got.hit) begin failures++; $display("FAIL resp_hit got=%b want=%b", resp_hit, got.hit); end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL resp_pulse_width got=%b want=0", resp_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tb_clear = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 || cache_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b%b%b%b want=1000", req_ready, resp_valid, mem_req, cache_enable);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      failures++; $display("FAIL reset_counters got=%h/%h want=0/0", hit_count, miss_count);
    end
    checks++;
    if (resp_rdata !== '0 || write_index !== '0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%b want=0", resp_rdata, write_index, mem_we);
    end
    rst = 1'b0; tb_clear = 1'b0;
  endtask

  task automatic test_cold_miss();
    cache_line_t want;
    ack_delay = 3;
    do_req(LW, 22'h3, 8'h05, '0);
    want = '{valid: 1'b1, tag: 22'h3, data: 32'hDEADBEEF};
    checks++;
    if (arr[5] !== want) begin failures++; $display("FAIL fill_line got=%h want=%h", arr[5], want); end
    checks++;
    if (miss_count !== TB_STAT_W'(exp_misses)) begin
      failures++; $display("FAIL miss_count got=%0d want=%0d", miss_count, exp_misses);
    end
  endtask

  task automatic test_hit();
    do_req(LW, 22'h3, 8'h05, '0);
    checks++;
    if (hit_count !== TB_STAT_W'(exp_hits)) begin
      failures++; $display("FAIL hit_count got=%0d want=%0d", hit_count, exp_hits);
    end
  endtask

  task automatic test_store();
    cache_line_t want;
    logic [ADDR_W-1:0] a;
    a = {22'h7, 8'h05};
    do_req(SW, 22'h7, 8'h05, 32'h12345678);
    want = '{valid: 1'b1, tag: 22'h7, data: 32'h12345678};
    checks++;
    if (arr[5] !== want) begin failures++; $display("FAIL store_line got=%h want=%h", arr[5], want); end
    checks++;
    if (!dram.exists(a) || dram[a] !== 32'h12345678) begin
      failures++; $display("FAIL dram_write got=%h want=12345678", dram.exists(a) ? dram[a] : 'x);
    end
    do_req(LW, 22'h7, 8'h05, '0);
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw;
    ack_hold = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = {22'hA, 8'h20}; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL mid_mem_req got=%b want=1", mem_req); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_ctrl got=%b%b%b want=001", mem_req, resp_valid, req_ready);
    end
    checks++;
    if (hit_count !== '0 || miss_count !== '0) begin
      failures++; $display("FAIL mid_reset_counters got=%h/%h want=0/0", hit_count, miss_count);
    end
    rst = 1'b0; ack_hold = 1'b0; exp_hits = 0; exp_misses = 0;
    @(posedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    force_ack = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req || !req_ready) saw = 1'b1;
    end
    checks++;
    if (saw) begin failures++; $display("FAIL late_ack_effect got=1 want=0"); end
    do_req(LW, 22'hA, 8'h20, '0);
    checks++;
    if (miss_count !== TB_STAT_W'(exp_misses)) begin
      failures++; $display("FAIL mid_miss_count got=%0d want=%0d", miss_count, exp_misses);
    end
  endtask

  task automatic test_back_to_back();
    exp_t ea, eb, got;
    int la, lb, ma, mb, ca, cb, n, ready_bad, extra;
    bit seen;
    ack_delay = 2;
    predict(LW, 22'hB, 8'h30, '0, ea, la, ma, ca);
    predict(LW, 22'hB, 8'h30, '0, eb, lb, mb, cb);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_start got=%b want=1", req_ready); end
    req_valid = 1'b1; req_op = LW; req_addr = {22'hB, 8'h30}; req_wdata = '0;
    @(posedge clk);
    n = 0; seen = 1'b0; ready_bad = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (req_ready) ready_bad++;
      if (resp_valid) seen = 1'b1;
    end
    got = exp_q.pop_front();
    checks++;
    if (!seen || n != la) begin failures++; $display("FAIL b2b_first_latency got=%0d want=%0d", n, la); end
    checks++;
    if (ready_bad != 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d want=0", ready_bad); end
    checks++;
    if (resp_rdata !== got.rdata || resp_hit !== got.hit) begin
      failures++; $display("FAIL b2b_first_resp got=%h/%b want=%h/%b", resp_rdata, resp_hit, got.rdata, got.hit);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got=%b/%b want=1/0", req_ready, resp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%b want=0", req_ready); end
    @(negedge clk);
    got = exp_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || lb != 2) begin
      failures++; $display("FAIL b2b_second_resp got=%b want=1", resp_valid);
    end
    checks++;
    if (resp_rdata !== got.rdata || resp_hit !== got.hit) begin
      failures++; $display("FAIL b2b_second_data got=%h/%b want=%h/%b", resp_rdata, resp_hit, got.rdata, got.hit);
    end
    extra = 0;
    repeat (6) begin @(negedge clk); if (resp_valid) extra++; end
    checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_extra_resp got=%0d/%0d want=0/0", extra, exp_q.size());
    end
  endtask

  task automatic test_saturation();
    ack_delay = 1;
    for (int i = 0; i < 16; i++) do_req(LW, 22'hB, 8'h30, '0);
    checks++;
    if (hit_count !== TB_STAT_W'(exp_hits) || hit_count !== TB_STAT_W'(STAT_MAX)) begin
      failures++; $display("FAIL hit_saturate got=%0d want=%0d", hit_count, STAT_MAX);
    end
    for (int i = 0; i < 14; i++) do_req(LW, 22'h1, IDX_W'(32'h40 + i), '0);
    checks++;
    if (miss_count !== TB_STAT_W'(exp_misses) || miss_count !== TB_STAT_W'(STAT_MAX)) begin
      failures++; $display("FAIL miss_saturate got=%0d want=%0d", miss_count, STAT_MAX);
    end
    checks++;
    if (hit_count !== TB_STAT_W'(STAT_MAX)) begin
      failures++; $display("FAIL hit_hold got=%0d want=%0d", hit_count, STAT_MAX);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
